// File: rtl/aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher -- iterative AES-128 decryption core (FIPS-197 inverse cipher)
//
// One full inverse round is evaluated per clock. A block is accepted in IDLE
// with the initial AddRoundKey(rk10) already applied. Rounds 9..0 then run on
// consecutive cycles, and the plaintext is presented with a one-cycle ready
// pulse.
//
// Ports:
//   clk    in   1    clock, all state changes on posedge
//   rst    in   1    synchronous active-high reset, highest priority
//   start  in   1    in/key valid this cycle; ignored while busy
//   in     in   128  ciphertext, byte 0 at [127:120], column-major
//   key    in   128  cipher key, same byte order
//   out    out  128  plaintext, held until the next result
//   ready  out  1    one-cycle pulse, out valid this cycle
//   busy   out  1    high while a block is in flight
//
// This file also holds the shared GF(2^8) helper package and the
// keyexpansion round-key schedule.
// ---------------------------------------------------------------------------

package aes_inv_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // S-boxes are computed from field inverse + affine map, not stored tables.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// ---------------------------------------------------------------------------
// keyexpansion -- combinational AES-128 key schedule
//   key  in   128  cipher key
//   rk   out  1408 round key r at rk[128*r+127 : 128*r], r = 0..10
// ---------------------------------------------------------------------------
module keyexpansion
  import aes_inv_pkg::*;
(
  input  logic [127:0]  key,
  output logic [1407:0] rk
);

  logic [31:0] w [44];

  always_comb begin : expand
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) begin
      w[i] = key[127-32*i -: 32];
    end
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        w[i] = w[i-4] ^ sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {rc, 24'h000000};
        rc   = xtime(rc);
      end else begin
        w[i] = w[i-4] ^ w[i-1];
      end
    end
  end

  // Word 4r lands in the top 32 bits of round key r.
  for (genvar gi = 0; gi < 44; gi++) begin : g_rk
    assign rk[128*(gi/4) + 127 - 32*(gi%4) -: 32] = w[gi];
  end

endmodule

// ---------------------------------------------------------------------------
module aes_inv_cipher
  import aes_inv_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         ready,
  output logic         busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_cipher supports only NR = 10");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1
  } state_t;

  state_t        state_reg;
  logic [3:0]    round_reg;
  logic [127:0]  st_reg;
  logic [127:0]  key_q_reg;
  logic [127:0]  out_reg;
  logic          ready_reg;

  logic [127:0]  ke_key;
  logic [1407:0] rk;
  logic [127:0]  rk_cur;
  logic [127:0]  t;
  logic [127:0]  mixed;

  // In IDLE the schedule is fed the incoming key so rk10 is available for
  // the whitening step at the accept edge; afterwards it runs off key_q.
  assign ke_key = (state_reg == IDLE) ? key : key_q_reg;

  keyexpansion u_keyexpansion (
    .key (ke_key),
    .rk  (rk)
  );

  always_comb begin
    rk_cur = rk[127:0];
    for (int r = 1; r <= 10; r++) begin
      if (round_reg == 4'(r)) rk_cur = rk[128*r +: 128];
    end
  end

  // InvShiftRows folded into the byte wiring: output byte (row R, col C)
  // takes input byte (row R, col C-R mod 4). Then InvSubBytes and AddRoundKey.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    assign t[127-8*gi -: 8] = inv_sbox(st_reg[127-8*SRC -: 8]) ^ rk_cur[127-8*gi -: 8];
  end

  // InvMixColumns, {0e,0b,0d,09} circulant per column.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = t[127-32*gi -: 8];
    assign a1 = t[119-32*gi -: 8];
    assign a2 = t[111-32*gi -: 8];
    assign a3 = t[103-32*gi -: 8];
    assign mixed[127-32*gi -: 32] = {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      round_reg <= 4'd0;
      st_reg    <= '0;
      key_q_reg <= '0;
      out_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            st_reg    <= in ^ rk[1407:1280];
            round_reg <= 4'd9;
            key_q_reg <= key;
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          if (round_reg != 4'd0) begin
            st_reg    <= mixed;
            round_reg <= round_reg - 4'd1;
          end else begin
            out_reg   <= t;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out   = out_reg;
  assign ready = ready_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher -- self-checking bench for aes_inv_cipher
//
// Directed known-answer vectors, busy/ready timing, ignored start while busy,
// back-to-back accept in the ready cycle, mid-block reset and randomized
// blocks against a table-driven byte-array reference decryptor.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher;

  localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2P = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V3K = 128'h0;
  localparam logic [127:0] V3C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] V3P = 128'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] din;
  logic [127:0] dkey;
  logic [127:0] dout;
  logic         ready;
  logic         busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  aes_inv_cipher #(.NR(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (din),
    .key   (dkey),
    .out   (dout),
    .ready (ready),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // Walk the field with generator 3 and its inverse to fill the S-box table.
  task automatic build_tables;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    sbox_t[0] = 8'h63;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [7:0]   ks [176];
    logic [7:0]   s  [16];
    logic [7:0]   t  [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc, tmp, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) ks[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tw[j] = ks[i-4+j];
      if (i % 16 == 0) begin
        tmp   = tw[0];
        tw[0] = sbox_t[tw[1]] ^ rc;
        tw[1] = sbox_t[tw[2]];
        tw[2] = sbox_t[tw[3]];
        tw[3] = sbox_t[tmp];
        rc    = m_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) ks[i+j] = ks[i-16+j] ^ tw[j];
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[160+i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = s[r + 4*((c - r + 4) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isbox_t[t[i]] ^ ks[16*rnd+i];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h0e) ^ m_mul(a1, 8'h0b) ^ m_mul(a2, 8'h0d) ^ m_mul(a3, 8'h09);
          s[4*c+1] = m_mul(a0, 8'h09) ^ m_mul(a1, 8'h0e) ^ m_mul(a2, 8'h0b) ^ m_mul(a3, 8'h0d);
          s[4*c+2] = m_mul(a0, 8'h0d) ^ m_mul(a1, 8'h09) ^ m_mul(a2, 8'h0e) ^ m_mul(a3, 8'h0b);
          s[4*c+3] = m_mul(a0, 8'h0b) ^ m_mul(a1, 8'h0d) ^ m_mul(a2, 8'h09) ^ m_mul(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  // mode 0: plain; 1: scramble key/in after accept; 2: pulse start with
  // vector 2 at cycles 3 and 7 while busy.
  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp, input int mode);
    int lat, busy_cnt, rdy_cnt;
    logic [127:0] got;
    lat = 0; busy_cnt = 0; rdy_cnt = 0; got = '0;
    @(negedge clk);
    start = 1'b1; dkey = k; din = ct;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (ready) begin
        rdy_cnt++;
        if (lat == 0) begin
          lat = c - 1;
          got = dout;
        end
      end
      start = 1'b0;
      if (mode == 1) begin
        dkey = {$urandom, $urandom, $urandom, $urandom};
        din  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mode == 2 && (c == 3 || c == 7)) begin
        start = 1'b1; dkey = V2K; din = V2C;
      end
    end
    $display("blk %s key=%h in=%h out=%h lat=%0d busy=%0d readies=%0d",
             tag, k, ct, got, lat, busy_cnt, rdy_cnt);
    check({tag, ".out"}, got, exp);
    check({tag, ".latency"}, 128'(lat), 128'd10);
    check({tag, ".busy_cycles"}, 128'(busy_cnt), 128'd10);
    check({tag, ".ready_pulses"}, 128'(rdy_cnt), 128'd1);
    check({tag, ".out_hold"}, dout, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, rdy_cnt;
    logic [127:0] got1, got2, rk_v, rc_v, rp_v;
    build_tables();

    rst = 1'b1; start = 1'b0; din = '0; dkey = '0;
    repeat (3) @(negedge clk);
    check("reset.out", dout, 128'h0);
    check("reset.ready", 128'(ready), 128'h0);
    check("reset.busy", 128'(busy), 128'h0);
    rst = 1'b0;

    run_block("v1", V1K, V1C, V1P, 0);
    run_block("v2", V2K, V2C, V2P, 0);
    run_block("v3_scramble", V3K, V3C, V3P, 1);
    run_block("v1_ignore_start", V1K, V1C, V1P, 2);

    // Back-to-back: vector 2 started in vector 1's ready cycle.
    first = 0; second = 0; got1 = '0; got2 = '0;
    @(negedge clk);
    start = 1'b1; dkey = V1K; din = V1C;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready) begin
        if (first == 0) begin
          first = c; got1 = dout;
          start = 1'b1; dkey = V2K; din = V2C;
        end else if (second == 0) begin
          second = c; got2 = dout;
        end
      end
    end
    $display("b2b first=%h second=%h gap=%0d", got1, got2, second - first);
    check("b2b.first", got1, V1P);
    check("b2b.second", got2, V2P);
    check("b2b.gap", 128'(second - first), 128'd11);

    // Reset in the middle of vector 1 (round 5 in flight).
    @(negedge clk);
    start = 1'b1; dkey = V1K; din = V1C;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("midreset busy=%0d ready=%0d out=%h", busy, ready, dout);
    check("midreset.busy", 128'(busy), 128'h0);
    check("midreset.ready", 128'(ready), 128'h0);
    check("midreset.out", dout, 128'h0);
    rdy_cnt = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    check("midreset.no_ready", 128'(rdy_cnt), 128'd0);
    run_block("v1_after_reset", V1K, V1C, V1P, 0);

    // Randomized blocks against the reference model.
    for (int i = 0; i < 12; i++) begin
      rk_v = {$urandom, $urandom, $urandom, $urandom};
      rc_v = {$urandom, $urandom, $urandom, $urandom};
      rp_v = ref_decrypt(rc_v, rk_v);
      run_block($sformatf("rand%0d", i), rk_v, rc_v, rp_v, i % 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
